// File: rtl/tpu_job_scheduler_if.sv
// tpu_job_scheduler_if: requester, operand-memory and matrix-unit signals of the job scheduler
interface tpu_job_scheduler_if;
  logic [1:0] req;
  logic [2:0] cfg0;
  logic [2:0] cfg1;
  logic       in_valid0;
  logic       in_valid1;
  logic [7:0] in_data0;
  logic [7:0] in_data1;
  logic [1:0] gnt;
  logic       in_ready;
  logic       load_en;
  logic [7:0] load_data;
  logic [2:0] mode;
  logic       mmu_start;
  logic       res_valid;
  logic [7:0] res_data;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_id;
  logic       done;
  logic       err;
  modport master (
    output req, cfg0, cfg1, in_valid0, in_valid1, in_data0, in_data1, res_valid, res_data,
    input  gnt, in_ready, load_en, load_data, mode, mmu_start, out_valid, out_data, out_id, done, err
  );
  modport slave (
    input  req, cfg0, cfg1, in_valid0, in_valid1, in_data0, in_data1, res_valid, res_data,
    output gnt, in_ready, load_en, load_data, mode, mmu_start, out_valid, out_data, out_id, done, err
  );
endinterface

// File: rtl/tpu_job_scheduler.sv
// tpu_job_scheduler: round-robin arbitration and load/start/collect sequencing of the shared 2x2 matrix unit
module tpu_job_scheduler #(
  parameter int LOAD_BYTES   = 8,
  parameter int RESULT_BYTES = 8,
  parameter int TIMEOUT      = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  tpu_job_scheduler_if.slave  bus
);
  localparam int MAXB = LOAD_BYTES > RESULT_BYTES ? LOAD_BYTES : RESULT_BYTES;
  localparam int CW   = $clog2(MAXB) + 1;
  localparam int TW   = $clog2(TIMEOUT) + 1;
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, START, WAIT, DONE} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          win_q, win_d;
  logic          last_q, last_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          in_ready_q, in_ready_d;
  logic          load_en_q, load_en_d;
  logic [7:0]    load_data_q, load_data_d;
  logic [2:0]    mode_q, mode_d;
  logic          mmu_start_q, mmu_start_d;
  logic          out_valid_q, out_valid_d;
  logic [7:0]    out_data_q, out_data_d;
  logic          out_id_q, out_id_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          pick;
  logic          win_req;
  logic          win_valid;
  logic [7:0]    win_data;
  always_comb begin
    pick        = &bus.req ? ~last_q : bus.req[1];
    win_req     = win_q ? bus.req[1] : bus.req[0];
    win_valid   = win_q ? bus.in_valid1 : bus.in_valid0;
    win_data    = win_q ? bus.in_data1 : bus.in_data0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    win_d       = win_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    mode_d      = mode_q;
    load_en_d   = 1'b0;
    load_data_d = load_data_q;
    mmu_start_d = 1'b0;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: if (|bus.req) begin
        state_d = LOAD;
        win_d   = pick;
        gnt_d   = pick ? 2'b10 : 2'b01;
        mode_d  = pick ? bus.cfg1 : bus.cfg0;
        cnt_d   = '0;
      end
      // losing the request aborts the job even if a byte is offered in the same cycle
      LOAD: if (!win_req) begin
        state_d = DONE;
        done_d  = 1'b1;
        err_d   = 1'b1;
      end else if (in_ready_q && win_valid) begin
        cnt_d       = cnt_q + 1'b1;
        load_en_d   = 1'b1;
        load_data_d = win_data;
        state_d     = cnt_d == CW'(LOAD_BYTES) ? SETTLE : LOAD;
      end
      SETTLE: begin
        state_d     = START;
        mmu_start_d = 1'b1;
      end
      START: begin
        state_d = WAIT;
        cnt_d   = '0;
        tmo_d   = '0;
      end
      WAIT: if (bus.res_valid) begin
        out_valid_d = 1'b1;
        out_data_d  = bus.res_data;
        out_id_d    = win_q;
        cnt_d       = cnt_q + 1'b1;
        tmo_d       = '0;
        done_d      = cnt_d == CW'(RESULT_BYTES);
        state_d     = done_d ? DONE : WAIT;
      end else begin
        tmo_d   = tmo_q + 1'b1;
        done_d  = tmo_d == TW'(TIMEOUT);
        err_d   = done_d;
        state_d = done_d ? DONE : WAIT;
      end
      DONE: begin
        state_d = IDLE;
        last_d  = win_q;
        gnt_d   = '0;
        mode_d  = '0;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = state_d == LOAD;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tmo_q       <= '0;
      win_q       <= 1'b0;
      last_q      <= 1'b1;
      gnt_q       <= '0;
      in_ready_q  <= 1'b0;
      load_en_q   <= 1'b0;
      load_data_q <= '0;
      mode_q      <= '0;
      mmu_start_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      win_q       <= win_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      in_ready_q  <= in_ready_d;
      load_en_q   <= load_en_d;
      load_data_q <= load_data_d;
      mode_q      <= mode_d;
      mmu_start_q <= mmu_start_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end
  assign bus.gnt       = gnt_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.load_en   = load_en_q;
  assign bus.load_data = load_data_q;
  assign bus.mode      = mode_q;
  assign bus.mmu_start = mmu_start_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_id    = out_id_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_tpu_job_scheduler.sv
// tb_tpu_job_scheduler: job table plus randomized jobs checked cycle by cycle against a job-level model
module tb_tpu_job_scheduler;
  localparam int LB = 8;
  localparam int RB = 8;
  localparam int TO = 64;
  typedef struct {
    logic [1:0] req;
    logic [2:0] c0;
    logic [2:0] c1;
    int         bp;
    int         abort_after;
    int         nres;
    bit         tgap;
    int         rst_after;
    bit         rnd;
    logic [1:0] exp_gnt;
  } job_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  logic last_m = 1'b1;
  job_t tbl[12];
  job_t rj;
  logic rw;
  always #5 clk = ~clk;
  tpu_job_scheduler_if bus();
  tpu_job_scheduler #(.LOAD_BYTES(LB), .RESULT_BYTES(RB), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic chk_zero(input string n);
    chk(n, {4'b0, bus.gnt, bus.in_ready, bus.load_en, bus.load_data, bus.mode, bus.mmu_start,
            bus.out_valid, bus.out_data, bus.out_id, bus.done, bus.err}, 32'd0);
  endtask
  task automatic run_job(input job_t j);
    logic [7:0] bytes[LB];
    logic w, ev, rv, exp_ov, exp_done, exp_err;
    logic [7:0] rd, exp_od;
    int acc, cyc, sent, got, idle, gap;
    bit fin;
    w = j.exp_gnt[1];
    for (int i = 0; i < LB; i++) bytes[i] = j.rnd ? 8'($urandom) : 8'(i + 1);
    bus.req = j.req;
    bus.cfg0 = j.c0;
    bus.cfg1 = j.c1;
    bus.in_valid0 = 1'b0;
    bus.in_valid1 = 1'b0;
    bus.res_valid = 1'($urandom);
    bus.res_data = 8'($urandom);
    @(negedge clk);
    chk("grant", bus.gnt, j.exp_gnt);
    chk("in_ready_grant", bus.in_ready, 1);
    chk("mode", bus.mode, w ? j.c1 : j.c0);
    chk("out_valid_idle", bus.out_valid, 0);
    acc = 0;
    cyc = 0;
    while (acc < LB && cyc < 200) begin
      if (j.abort_after != 0 && acc == j.abort_after) begin
        bus.req[w] = 1'b0;
        bus.in_valid0 = 1'b0;
        bus.in_valid1 = 1'b0;
        @(negedge clk);
        chk("abort_done", bus.done, 1);
        chk("abort_err", bus.err, 1);
        chk("abort_load_en", bus.load_en, 0);
        chk("abort_no_start", bus.mmu_start, 0);
        @(negedge clk);
        chk("abort_idle", {bus.gnt, bus.done, bus.mode, bus.mmu_start}, 0);
        last_m = w;
        return;
      end
      ev = j.bp == 0 ? 1'b1 : j.bp == 1 ? 1'(cyc % 2 == 0) : 1'($urandom);
      if (w) begin
        bus.in_valid1 = ev;
        bus.in_data1 = bytes[acc];
        bus.in_valid0 = 1'($urandom);
        bus.in_data0 = 8'($urandom);
      end else begin
        bus.in_valid0 = ev;
        bus.in_data0 = bytes[acc];
        bus.in_valid1 = 1'($urandom);
        bus.in_data1 = 8'($urandom);
      end
      if (j.rnd) bus.req[~w] = 1'($urandom);
      bus.res_valid = 1'($urandom);
      @(negedge clk);
      cyc++;
      chk("load_en", bus.load_en, ev);
      if (ev) begin
        chk("load_data", bus.load_data, bytes[acc]);
        acc++;
      end
      chk("mmu_start_in_load", bus.mmu_start, 0);
      chk("out_valid_in_load", bus.out_valid, 0);
      chk("in_ready_load", bus.in_ready, acc < LB);
    end
    if (acc < LB) chk("load_bound", acc, LB);
    bus.in_valid0 = 1'($urandom);
    bus.in_valid1 = 1'($urandom);
    bus.res_valid = 1'($urandom);
    @(negedge clk);
    chk("mmu_start", bus.mmu_start, 1);
    chk("load_en_start", bus.load_en, 0);
    chk("out_valid_settle", bus.out_valid, 0);
    bus.in_valid0 = 1'b0;
    bus.in_valid1 = 1'b0;
    bus.res_valid = 1'($urandom);
    if (j.rnd) bus.req = 2'($urandom);
    @(negedge clk);
    chk("mmu_start_pulse", bus.mmu_start, 0);
    exp_ov = 1'b0;
    exp_od = '0;
    exp_done = 1'b0;
    exp_err = 1'b0;
    got = 0;
    sent = 0;
    idle = 0;
    gap = 0;
    cyc = 0;
    fin = 0;
    while (!fin && cyc < 2000) begin
      chk("out_valid", bus.out_valid, exp_ov);
      if (exp_ov) begin
        chk("out_data", bus.out_data, exp_od);
        chk("out_id", bus.out_id, w);
      end
      chk("done", bus.done, exp_done);
      if (exp_done) begin
        chk("err", bus.err, exp_err);
        fin = 1;
      end else begin
        if (j.rst_after != 0 && cyc == j.rst_after) begin
          #2 rst_n = 1'b0;
          #1 chk_zero("reset_async");
          bus.req = 2'b00;
          bus.res_valid = 1'b0;
          @(negedge clk);
          chk_zero("reset_held");
          rst_n = 1'b1;
          last_m = 1'b1;
          return;
        end
        rv = sent < j.nres && (j.tgap ? gap == TO - 1 : $urandom_range(0, 3) != 0);
        rd = 8'($urandom);
        bus.res_valid = rv;
        bus.res_data = rd;
        if (rv) begin
          sent++;
          got++;
          idle = 0;
          gap = 0;
        end else begin
          idle++;
          gap++;
        end
        exp_ov = rv;
        exp_od = rd;
        exp_done = got == RB || idle == TO;
        exp_err = got != RB;
        @(negedge clk);
        cyc++;
      end
    end
    if (!fin) chk("wait_bound", 0, 1);
    bus.res_valid = 1'($urandom);
    @(negedge clk);
    chk("after_done", {bus.gnt, bus.mode, bus.done, bus.in_ready, bus.out_valid, bus.mmu_start}, 0);
    last_m = w;
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tbl[0]  = '{2'b11, 3'b101, 3'b010, 0, 0, 8, 1'b0, 0, 1'b0, 2'b01};
    tbl[1]  = '{2'b11, 3'b101, 3'b010, 0, 0, 8, 1'b0, 0, 1'b0, 2'b10};
    tbl[2]  = '{2'b11, 3'b011, 3'b110, 0, 0, 8, 1'b0, 0, 1'b0, 2'b01};
    tbl[3]  = '{2'b10, 3'b000, 3'b111, 1, 0, 8, 1'b0, 0, 1'b0, 2'b10};
    tbl[4]  = '{2'b01, 3'b101, 3'b000, 0, 0, 8, 1'b0, 0, 1'b0, 2'b01};
    tbl[5]  = '{2'b01, 3'b001, 3'b000, 0, 3, 8, 1'b0, 0, 1'b0, 2'b01};
    tbl[6]  = '{2'b10, 3'b000, 3'b100, 0, 0, 0, 1'b0, 0, 1'b0, 2'b10};
    tbl[7]  = '{2'b11, 3'b010, 3'b001, 0, 0, 4, 1'b0, 0, 1'b0, 2'b01};
    tbl[8]  = '{2'b10, 3'b000, 3'b011, 2, 0, 8, 1'b1, 0, 1'b1, 2'b10};
    tbl[9]  = '{2'b01, 3'b110, 3'b000, 2, 0, 4, 1'b1, 0, 1'b1, 2'b01};
    tbl[10] = '{2'b11, 3'b001, 3'b111, 0, 0, 8, 1'b0, 5, 1'b0, 2'b10};
    tbl[11] = '{2'b11, 3'b100, 3'b010, 0, 0, 8, 1'b0, 0, 1'b0, 2'b01};
    bus.req = 2'b11;
    bus.cfg0 = 3'b111;
    bus.cfg1 = 3'b111;
    bus.in_valid0 = 1'b1;
    bus.in_valid1 = 1'b1;
    bus.in_data0 = 8'hff;
    bus.in_data1 = 8'hff;
    bus.res_valid = 1'b1;
    bus.res_data = 8'hff;
    #1 chk_zero("reset_state");
    repeat (3) @(negedge clk);
    chk_zero("reset_state_clocked");
    bus.req = 2'b00;
    bus.in_valid0 = 1'b0;
    bus.in_valid1 = 1'b0;
    bus.res_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("after_release");
    for (int i = 0; i < 12; i++) run_job(tbl[i]);
    for (int n = 0; n < 40; n++) begin
      rj.req = 2'($urandom_range(1, 3));
      rj.c0 = 3'($urandom);
      rj.c1 = 3'($urandom);
      rj.bp = $urandom_range(0, 2);
      rj.abort_after = $urandom_range(0, 4) == 0 ? $urandom_range(1, LB - 1) : 0;
      rj.nres = $urandom_range(0, 3) == 0 ? $urandom_range(0, RB - 1) : RB;
      rj.tgap = 1'b0;
      rj.rst_after = 0;
      rj.rnd = 1'b1;
      rw = rj.req == 2'b11 ? ~last_m : rj.req[1];
      rj.exp_gnt = rw ? 2'b10 : 2'b01;
      run_job(rj);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
